// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch: one bus read per PC, result held for decode until accepted; flush discards stale responses.
// Optional FETCH_ADDR_MAP_EN folds kseg0/kseg1 PCs to physical bus addresses; min fetch period 3 cycles.
module inst_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  input  logic              stall_i,
  output logic              pc_stall,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_adel
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] req_pc;
  logic              misaligned;
  logic              req_fire, cap_adel, cap_data, clr_valid;

  assign misaligned = (pc[1:0] != 2'b00);
  assign inst_req   = (state == S_REQ) && !flush && !rst && !misaligned;
  assign pc_stall   = !((state == S_HOLD) && !stall_i && !flush);

`ifdef FETCH_ADDR_MAP_EN
  assign inst_addr = {{(ADDR_W-29){1'b0}}, pc[28:0]};
`else
  assign inst_addr = pc;
`endif

  always_comb begin
    state_nxt = state;
    req_fire  = 1'b0;
    cap_adel  = 1'b0;
    cap_data  = 1'b0;
    clr_valid = 1'b0;
    case (state)
      S_REQ: begin
        if (!flush) begin
          if (misaligned) begin
            cap_adel  = 1'b1;
            state_nxt = S_HOLD;
          end else if (inst_addr_ok) begin
            req_fire  = 1'b1;
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A flush with data already back needs no drop phase; otherwise wait out the stale response.
        if (flush) begin
          state_nxt = inst_data_ok ? S_REQ : S_DROP;
        end else if (inst_data_ok) begin
          cap_data  = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_DROP: begin
        if (inst_data_ok) state_nxt = S_REQ;
      end
      S_HOLD: begin
        if (flush || !stall_i) begin
          clr_valid = 1'b1;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      req_pc     <= '0;
      inst_valid <= 1'b0;
      inst_o     <= '0;
      inst_pc    <= '0;
      inst_adel  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (req_fire) req_pc <= pc;
      if (cap_adel) begin
        inst_o     <= '0;
        inst_pc    <= pc;
        inst_adel  <= 1'b1;
        inst_valid <= 1'b1;
      end else if (cap_data) begin
        inst_o     <= inst_rdata;
        inst_pc    <= req_pc;
        inst_adel  <= 1'b0;
        inst_valid <= 1'b1;
      end else if (clr_valid) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a transaction-level reference model checked every cycle.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, stall_i, inst_addr_ok, inst_data_ok;
  logic [31:0] pc, inst_rdata;
  logic        pc_stall, inst_req, inst_valid, inst_adel;
  logic [31:0] inst_addr, inst_o, inst_pc;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Model: a held instruction for decode, and at most one outstanding read that may be poisoned by a flush.
  bit          m_held;
  logic [31:0] m_o, m_pc;
  bit          m_adel;
  bit          m_out, m_poison;
  logic [31:0] m_out_pc;

  inst_fetch_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush), .stall_i(stall_i),
    .pc_stall(pc_stall), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .inst_valid(inst_valid), .inst_o(inst_o), .inst_pc(inst_pc), .inst_adel(inst_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] map_addr(input logic [31:0] a);
`ifdef FETCH_ADDR_MAP_EN
    return {3'b000, a[28:0]};
`else
    return a;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_held = 0; m_out = 0; m_poison = 0;
    end else if (m_held) begin
      if (flush || !stall_i) m_held = 0;
    end else if (m_out) begin
      if (inst_data_ok) begin
        m_out = 0;
        if (!m_poison && !flush) begin
          m_held = 1; m_o = inst_rdata; m_pc = m_out_pc; m_adel = 0;
        end
      end else if (flush) begin
        m_poison = 1;
      end
    end else if (!flush) begin
      if (pc[1:0] != 2'b00) begin
        m_held = 1; m_o = 0; m_pc = pc; m_adel = 1;
      end else if (inst_addr_ok) begin
        m_out = 1; m_out_pc = pc; m_poison = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("inst_req",  {31'b0, inst_req},
            {31'b0, !m_held && !m_out && !flush && !rst && pc[1:0] == 2'b00});
      check("pc_stall",  {31'b0, pc_stall}, {31'b0, !(m_held && !stall_i && !flush)});
      check("inst_addr", inst_addr, map_addr(pc));
      check("inst_valid", {31'b0, inst_valid}, {31'b0, m_held});
      if (m_held) begin
        check("inst_o",    inst_o, m_o);
        check("inst_pc",   inst_pc, m_pc);
        check("inst_adel", {31'b0, inst_adel}, {31'b0, m_adel});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_reset_values(input string tag);
    check({tag, "_valid"}, {31'b0, inst_valid}, 32'd0);
    check({tag, "_o"},     inst_o, 32'd0);
    check({tag, "_pc"},    inst_pc, 32'd0);
    check({tag, "_adel"},  {31'b0, inst_adel}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] boot_addr;
`ifdef FETCH_ADDR_MAP_EN
    boot_addr = 32'h1fc00000;
`else
    boot_addr = 32'hbfc00000;
`endif
    rst = 1; flush = 0; stall_i = 0; inst_addr_ok = 0; inst_data_ok = 0;
    inst_rdata = 0; pc = 32'hbfc00000;
    cyc();
    chk_en = 1;
    cyc();
    expect_reset_values("rst0");
    check("rst0_req", {31'b0, inst_req}, 32'd0);

    // Boot fetch: addr_ok on release, data_ok one cycle later.
    rst = 0; inst_addr_ok = 1; settle();
    check("boot_req",  {31'b0, inst_req}, 32'd1);
    check("boot_addr", inst_addr, boot_addr);
    cyc();
    inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h3c087fff;
    cyc();
    inst_data_ok = 0; inst_rdata = 0; settle();
    check("boot_valid", {31'b0, inst_valid}, 32'd1);
    check("boot_o",     inst_o, 32'h3c087fff);
    check("boot_pc",    inst_pc, 32'hbfc00000);
    check("boot_stall", {31'b0, pc_stall}, 32'd0);
    cyc();
    pc = 32'hbfc00004; settle();
    check("boot_done", {31'b0, inst_valid}, 32'd0);
    check("boot_stall_after", {31'b0, pc_stall}, 32'd1);

    // Decode stall held for 4 cycles in the hold phase.
    inst_addr_ok = 1; cyc();
    inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h8d090004; stall_i = 1; cyc();
    inst_data_ok = 0; inst_rdata = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("stall_o",     inst_o, 32'h8d090004);
      check("stall_pcst",  {31'b0, pc_stall}, 32'd1);
      check("stall_req",   {31'b0, inst_req}, 32'd0);
      cyc();
    end
    stall_i = 0; settle();
    check("unstall_pcst", {31'b0, pc_stall}, 32'd0);
    cyc();
    pc = 32'hbfc00008;

    // Flush after addr_ok; stale data arrives 3 cycles later.
    inst_addr_ok = 1; cyc();
    inst_addr_ok = 0; flush = 1; cyc();
    flush = 0; pc = 32'hbfc00380; settle();
    check("drop_req", {31'b0, inst_req}, 32'd0);
    cyc(); cyc();
    inst_data_ok = 1; inst_rdata = 32'hdeadbeef; cyc();
    inst_data_ok = 0; inst_rdata = 0; settle();
    check("drop_valid", {31'b0, inst_valid}, 32'd0);
    check("redir_req",  {31'b0, inst_req}, 32'd1);
    check("redir_addr", inst_addr, map_addr(32'hbfc00380));
    inst_addr_ok = 1; cyc();
    inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h24080001; cyc();
    inst_data_ok = 0; inst_rdata = 0; settle();
    check("redir_o",  inst_o, 32'h24080001);
    check("redir_pc", inst_pc, 32'hbfc00380);
    cyc();
    pc = 32'hbfc00384;

    // Flush coincident with data_ok while waiting.
    inst_addr_ok = 1; cyc();
    inst_addr_ok = 0; flush = 1; inst_data_ok = 1; inst_rdata = 32'h0badf00d; cyc();
    flush = 0; inst_data_ok = 0; inst_rdata = 0; pc = 32'hbfc00400; settle();
    check("coinc_valid", {31'b0, inst_valid}, 32'd0);
    check("coinc_req",   {31'b0, inst_req}, 32'd1);
    inst_addr_ok = 1; cyc();
    inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h00851021; cyc();
    inst_data_ok = 0; inst_rdata = 0; settle();
    check("coinc_next_pc", inst_pc, 32'hbfc00400);
    cyc();

    // Misaligned PC: address error without a bus request.
    pc = 32'hbfc00002; inst_addr_ok = 1; settle();
    check("adel_req", {31'b0, inst_req}, 32'd0);
    cyc();
    inst_addr_ok = 0; settle();
    check("adel_valid", {31'b0, inst_valid}, 32'd1);
    check("adel_flag",  {31'b0, inst_adel}, 32'd1);
    check("adel_o",     inst_o, 32'd0);
    check("adel_pc",    inst_pc, 32'hbfc00002);
    cyc();
    pc = 32'hbfc00404;

    // Fetches with varying response latency and decode stalls.
    for (int k = 1; k <= 3; k++) begin
      inst_addr_ok = 1; cyc();
      inst_addr_ok = 0;
      for (int w = 1; w < k; w++) cyc();
      inst_data_ok = 1; inst_rdata = 32'h1000 + k; stall_i = (k == 2); cyc();
      inst_data_ok = 0; inst_rdata = 0;
      if (k == 2) begin cyc(); stall_i = 0; end
      settle();
      check("lat_pc", inst_pc, pc);
      cyc();
      pc = pc + 4;
    end

    // Reset while a read is outstanding; the late response is ignored.
    inst_addr_ok = 1; cyc();
    inst_addr_ok = 0; rst = 1; settle();
    check("rstw_req", {31'b0, inst_req}, 32'd0);
    cyc();
    expect_reset_values("rstw");
    rst = 0; inst_data_ok = 1; inst_rdata = 32'hcafef00d; cyc();
    inst_data_ok = 0; inst_rdata = 0; cyc();
    check("rstw_late_valid", {31'b0, inst_valid}, 32'd0);
    cyc();

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction-fetch controller between the program-counter register and the SRAM-like instruction bus. It turns the current PC into one bus read per instruction. It buffers the returned word with its PC for the decode stage and tells the PC register when to advance. On a pipeline redirect (flush), it discards any stale in-flight response so that only instructions from the new PC reach decode.

## Interface
Parameters:
- `ADDR_W`, 32, address and PC width.
- `DATA_W`, 32, instruction width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc`  in  ADDR_W  current PC from the PC register. After reset the PC register presents `32'hbfc00000`.
- `flush`  in  1  redirect this cycle; the PC register loads its target on the same edge.
- `stall_i`  in  1  decode stage cannot accept an instruction this cycle.
- `pc_stall`  out  1  hold the PC; drives the PC register enable as its inverse.
- `inst_req`  out  1  bus read request.
- `inst_addr`  out  ADDR_W  bus read address.
- `inst_addr_ok`  in  1  bus accepted the request this cycle.
- `inst_data_ok`  in  1  read data valid this cycle.
- `inst_rdata`  in  DATA_W  read data.
- `inst_valid`  out  1  `inst_o`, `inst_pc` and `inst_adel` are valid.
- `inst_o`  out  DATA_W  fetched instruction.
- `inst_pc`  out  ADDR_W  PC of `inst_o`.
- `inst_adel`  out  1  fetch address error (`pc[1:0]!=0`); `inst_o` is 0.

## Operation
- States: `S_REQ`, `S_WAIT`, `S_HOLD`, `S_DROP`. Reset state is `S_REQ`.
- Reset values: `inst_valid=0`, `inst_o=0`, `inst_pc=0`, `inst_adel=0`, internal `req_pc=0`.
- `inst_req = (state==S_REQ) && !flush && !rst && pc[1:0]==0`.
- `inst_addr` is the mapped `pc` (see Configuration).
- `S_REQ`:
  - `flush`: stay in `S_REQ`; no request is issued.
  - Misaligned `pc`: capture `inst_o=0`, `inst_pc=pc`, `inst_adel=1`, `inst_valid=1`; go to `S_HOLD`; no bus request.
  - `inst_req && inst_addr_ok`: `req_pc<=pc`; go to `S_WAIT`.
  - Otherwise stay in `S_REQ`.
- `S_WAIT`:
  - `flush`: if `inst_data_ok` in the same cycle, drop the data and go to `S_REQ`; otherwise go to `S_DROP`.
  - `inst_data_ok`: capture `inst_o=inst_rdata`, `inst_pc=req_pc`, `inst_adel=0`, `inst_valid=1`; go to `S_HOLD`.
- `S_DROP`: `inst_data_ok` drops the data and moves to `S_REQ`. `flush` has no additional effect here.
- `S_HOLD`:
  - `flush`: `inst_valid<=0`; go to `S_REQ`.
  - `!stall_i` (handoff): `inst_valid<=0`; go to `S_REQ`.
  - Otherwise hold all outputs stable.
- `pc_stall = !(state==S_HOLD && !stall_i && !flush)`. The PC advances exactly once per handed-off instruction.
- `inst_data_ok` outside `S_WAIT`/`S_DROP` is ignored. The bus shares `rst`, so nothing is outstanding after reset.
- At most one request is outstanding at any time.

## Timing
- `inst_data_ok` for a request arrives no earlier than the cycle after its `inst_addr_ok`.
- If `addr_ok` is at cycle T and `data_ok` at T+k (k≥1), then `inst_valid` rises at T+k+1.
- With `stall_i=0`, handoff happens at T+k+1 and the next `inst_req` is at T+k+2, with the new PC. Minimum fetch period: 3 cycles.
- Misaligned PC: `inst_valid` is high the cycle after it is detected in `S_REQ`.
- `inst_req`, `inst_addr` and `pc_stall` are combinational from state and inputs. All other outputs are registered.
- Reset mid-transaction: the next edge forces `S_REQ` and the reset values. `inst_req=0` while `rst=1`.

## Configuration
- `FETCH_ADDR_MAP_EN` defined: `inst_addr = {3'b000, pc[28:0]}`, i.e. kseg0/kseg1 are mapped to physical addresses. `32'hbfc00000` → `32'h1fc00000`.
- `FETCH_ADDR_MAP_EN` undefined: `inst_addr = pc` unchanged.
- `inst_pc` always carries the unmapped PC.

## Test plan
- Reset release, `pc=32'hbfc00000`, bus `addr_ok` same cycle, `data_ok` one cycle later with `32'h3c087fff` → `inst_valid`, `inst_o=32'h3c087fff`, `inst_pc=32'hbfc00000`, `pc_stall=0` for 1 cycle. `inst_addr=32'h1fc00000` with the macro, `32'hbfc00000` without it.
- `stall_i=1` for 4 cycles during `S_HOLD` → outputs stable, `pc_stall=1`, no `inst_req`; `stall_i` drops → single handoff.
- `flush` in the cycle after `addr_ok`, with `data_ok` 3 cycles later carrying `32'hdeadbeef` → word never reaches `inst_valid`. The next request uses the new PC `32'hbfc00380`.
- `flush` coincident with `data_ok` in `S_WAIT` → data dropped; state is `S_REQ` next cycle.
- `pc=32'hbfc00002` → no `inst_req`; `inst_valid=1`, `inst_adel=1`, `inst_o=0`, `inst_pc=32'hbfc00002`.
- `rst` asserted in `S_WAIT` → next cycle all outputs are at their reset values; a later `inst_data_ok` pulse produces no `inst_valid`.
